// File: rtl/dotstar_chain_driver.sv
// DotStar (APA102) chain driver: local pixel store, frame sequencer and
// built-in SPI serializer (sclk idles low, MSB first, strip samples on rise).
module dotstar_chain_driver #(
    parameter int NUM_LEDS    = 8,
    parameter int CLK_DIV     = 2,
    parameter int COLOR_ORDER = 0,
    parameter int REFRESH_GAP = 16,
    localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic [4:0]    brightness,
    input  logic          refresh,
    input  logic          auto_refresh,
    output logic          busy,
    output logic          frame_done,
    output logic          sclk,
    output logic          mosi
);
    localparam int END_WORDS = (NUM_LEDS + 63) / 64;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (REFRESH_GAP > 1) ? $clog2(REFRESH_GAP) : 1;

    // DONE is the one-cycle frame_done slot between END and the next decision
    typedef enum logic [2:0] {IDLE, START, PIXEL, ENDW, DONE, GAP} state_e;

    state_e        state_q, state_d;
    logic          pend_q, pend_d;
    logic [4:0]    bri_q, bri_d;
    logic [DW-1:0] div_q, div_d;
    logic          ph_q, ph_d;
    logic [4:0]    bit_q, bit_d;
    logic [AW-1:0] word_q, word_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [31:0]   sh_q, sh_d;
    logic [23:0]   pix_q [NUM_LEDS];

    logic        active, load, bit_end, word_end;
    logic [23:0] pix_rd;
    logic [31:0] word_w;

    assign active   = state_q inside {START, PIXEL, ENDW};
    // first cycle of the first low half of a word
    assign load     = active && !ph_q && (div_q == '0) && (bit_q == '0);
    assign bit_end  = active && ph_q && (div_q == DW'(CLK_DIV - 1));
    assign word_end = bit_end && (bit_q == 5'd31);
    assign pix_rd   = pix_q[word_q];

    // The word being loaded is driven straight onto mosi in its load cycle,
    // so the first bit is valid for the whole first low half.
    assign busy       = active;
    assign frame_done = (state_q == DONE);
    assign sclk       = active && ph_q;
    assign mosi       = active && (load ? word_w[31] : sh_q[31]);

    // select the 32-bit word for the current sequencer position
    always_comb begin
        word_w = '0;
        case (state_q)
            PIXEL:   word_w = (COLOR_ORDER == 0)
                            ? {3'b111, bri_q, pix_rd[7:0], pix_rd[15:8], pix_rd[23:16]}
                            : {3'b111, bri_q, pix_rd};
            ENDW:    word_w = '1;
            default: word_w = '0;
        endcase
    end

    // next-state: bit timing, word sequencing, pending request and gap count
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        bri_d   = bri_q;
        div_d   = div_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        word_d  = word_q;
        gap_d   = gap_q;
        sh_d    = sh_q;
        if (active) begin
            if (refresh) pend_d = 1'b1;
            if (load) sh_d = word_w;
            if (div_q == DW'(CLK_DIV - 1)) begin
                div_d = '0;
                ph_d  = !ph_q;
                if (ph_q) begin
                    sh_d  = {sh_q[30:0], 1'b0};
                    bit_d = bit_q + 5'd1;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
            if (word_end) begin
                word_d = word_q + 1'b1;
                case (state_q)
                    START: begin
                        state_d = PIXEL;
                        word_d  = '0;
                    end
                    PIXEL: if (word_q == AW'(NUM_LEDS - 1)) begin
                        state_d = ENDW;
                        word_d  = '0;
                    end
                    default: if (word_q == AW'(END_WORDS - 1)) begin
                        state_d = DONE;
                        word_d  = '0;
                    end
                endcase
            end
        end else begin
            div_d  = '0;
            ph_d   = 1'b0;
            bit_d  = '0;
            word_d = '0;
            sh_d   = '0;
            case (state_q)
                IDLE: if (refresh || auto_refresh || pend_q) state_d = START;
                DONE: begin
                    if (pend_q || refresh)  state_d = START;
                    else if (auto_refresh)  state_d = (REFRESH_GAP == 0) ? START : GAP;
                    else                    state_d = IDLE;
                end
                GAP: begin
                    if (refresh)                               state_d = START;
                    else if (!auto_refresh)                    state_d = IDLE;
                    else if (gap_q == GW'(REFRESH_GAP - 1))   state_d = START;
                    else                                       gap_d = gap_q + 1'b1;
                end
                default: ;
            endcase
            if (state_d != GAP) gap_d = '0;
            if (state_d == START) begin
                pend_d = 1'b0;
                bri_d  = brightness;
            end
        end
    end

    // sequencer and serializer state
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            bri_q   <= '0;
            div_q   <= '0;
            ph_q    <= 1'b0;
            bit_q   <= '0;
            word_q  <= '0;
            gap_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            bri_q   <= bri_d;
            div_q   <= div_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            gap_q   <= gap_d;
            sh_q    <= sh_d;
        end
    end

    // pixel store; a write in a word's load cycle lands after the fetch
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) pix_q[i] <= '0;
        end else if (wr_en && (int'(wr_addr) < NUM_LEDS)) begin
            pix_q[wr_addr] <= wr_data;
        end
    end
endmodule
